// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin write arbiter in front of a DEPTH x N register bank.
// One grant per cycle; the granted write is issued as a one-hot enable pulse
// exactly one cycle after its handshake. Out-of-range addresses are accepted
// but dropped and counted.
module reg_write_arbiter #(
   parameter int N     = 16,
   parameter int DEPTH = 8,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req_valid,
   input  logic [4*AW-1:0]   req_addr,
   input  logic [4*N-1:0]    req_data,
   output logic [3:0]        req_ready,
   input  logic              hold,
   output logic [DEPTH-1:0]  wr_en,
   output logic [N-1:0]      wr_data,
   output logic              busy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

   state_t         state, state_nxt;
   logic [1:0]     ptr;
   logic [1:0]     gidx;
   logic           found;
   logic           hs;
   logic [AW-1:0]  sel_addr;
   logic [N-1:0]   sel_data;
   logic           addr_ok;
   logic           drop_q;
   logic [7:0]     error_drop;

   // Round-robin search: first valid requester starting at ptr.
   always_comb begin
      gidx  = '0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!found && req_valid[ptr + 2'(k)]) begin
            found = 1'b1;
            gidx  = ptr + 2'(k);
         end
      end
   end

   // Mux out the winner's address/data and check the address range.
   always_comb begin
      sel_addr = req_addr[gidx*AW +: AW];
      sel_data = req_data[gidx*N +: N];
      addr_ok  = ({1'b0, sel_addr} < DEPTH_W);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: hold forces STALL from anywhere.
   always_comb begin
      state_nxt = state;
      if (hold) state_nxt = STALL;
      else begin
         case (state)
            IDLE:    state_nxt = hs ? ISSUE : IDLE;
            ISSUE:   state_nxt = hs ? ISSUE : IDLE;
            STALL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM outputs: grant only outside STALL, with hold low and out of reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && found && !hold && state != STALL) req_ready[gidx] = 1'b1;
      hs = |(req_valid & req_ready);
   end

   // Issue stage: registering the pulse at the handshake edge gives the
   // one-cycle latency and lets reset discard a pending write for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         wr_en      <= '0;
         wr_data    <= '0;
         drop_q     <= 1'b0;
         error_drop <= '0;
      end else begin
         wr_en  <= '0;
         drop_q <= 1'b0;
         if (hs) begin
            ptr <= gidx + 2'd1;
            if (addr_ok) begin
               wr_en   <= DEPTH'(1) << sel_addr;
               wr_data <= sel_data;
            end else begin
               drop_q <= 1'b1;
               if (error_drop != 8'hFF) error_drop <= error_drop + 8'd1;
            end
         end
      end
   end

   // busy covers both real writes and completing drops.
   always_comb busy = (|wr_en) | drop_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter (N=16, DEPTH=6 so out-of-range addresses exist).
// A behavioural model predicts every output each cycle; directed sequences add
// literal checks that pin the model.
module tb_reg_write_arbiter;
   localparam int N = 16;
   localparam int DEPTH = 6;
   localparam int AW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req_valid;
   logic [4*AW-1:0]   req_addr;
   logic [4*N-1:0]    req_data;
   logic [3:0]        req_ready;
   logic              hold;
   logic [DEPTH-1:0]  wr_en;
   logic [N-1:0]      wr_data;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;

   reg_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .hold(hold),
      .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Register bank fed by the DUT outputs.
   logic [N-1:0] bank [DEPTH] = '{default: '0};
   always @(posedge clk)
      for (int i = 0; i < DEPTH; i++) if (wr_en[i]) bank[i] <= wr_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int             m_ptr = 0;
   bit             m_stall = 0;
   logic [DEPTH-1:0] m_wr_en = '0;
   logic [N-1:0]   m_wr_data = '0;
   bit             m_busy = 0;
   int             m_err = 0;
   logic [N-1:0]   m_reg [DEPTH] = '{default: '0};

   function automatic int exp_grant();
      if (rst_n !== 1'b1 || hold || m_stall) return -1;
      for (int k = 0; k < 4; k++)
         if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr <= 0; m_stall <= 0; m_wr_en <= '0; m_wr_data <= '0; m_busy <= 0; m_err <= 0;
      end else begin
         automatic int g = exp_grant();
         automatic int a;
         for (int i = 0; i < DEPTH; i++) if (m_wr_en[i]) m_reg[i] <= m_wr_data;
         m_stall <= hold;
         m_wr_en <= '0;
         m_busy  <= 0;
         if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            m_ptr  <= (g + 1) % 4;
            m_busy <= 1;
            if (a < DEPTH) begin
               m_wr_en   <= DEPTH'(1) << a;
               m_wr_data <= req_data[g*N +: N];
            end else begin
               m_err <= (m_err < 255) ? m_err + 1 : 255;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      automatic int g = exp_grant();
      automatic logic [3:0] er = (g >= 0) ? 4'(1 << g) : 4'b0;
      chk("m_req_ready", 32'(req_ready), 32'(er));
      chk("m_wr_en",     32'(wr_en),     32'(m_wr_en));
      chk("m_wr_data",   32'(wr_data),   32'(m_wr_data));
      chk("m_busy",      32'(busy),      32'(m_busy));
      chk("m_error_drop",32'(dut.error_drop), 32'(m_err));
      chk("m_ptr",       32'(dut.ptr),   32'(m_ptr));
   end

   // ---------------- directed stimulus ----------------
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*N +: N]   = d;
   endtask

   typedef struct { logic [3:0] v; logic h; } mix_t;
   mix_t mix [10] = '{
      '{4'b1010, 1'b0}, '{4'b1111, 1'b0}, '{4'b0001, 1'b1}, '{4'b1001, 1'b0},
      '{4'b0110, 1'b0}, '{4'b1111, 1'b1}, '{4'b1111, 1'b0}, '{4'b0000, 1'b0},
      '{4'b1100, 1'b0}, '{4'b0011, 1'b0}};

   initial begin
      int e0;
      rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      repeat (2) nxt();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ptr", 32'(dut.ptr), 32'd0);

      // First grant right after reset release.
      nxt();
      rst_n = 1'b1;
      set_lane(0, 3'd3, 16'hA0A0); set_lane(2, 3'd5, 16'h0505);
      req_valid = 4'b0101;
      @(negedge clk); chk("first_ready", 32'(req_ready), 32'h1);
      nxt(); req_valid = '0;
      @(negedge clk);
      chk("first_wr_en", 32'(wr_en), 32'h08);
      chk("first_wr_data", 32'(wr_data), 32'hA0A0);
      chk("first_ptr", 32'(dut.ptr), 32'd1);
      chk("first_busy", 32'(busy), 32'd1);

      // Full rotation with all four requesters valid.
      nxt(); rst_n = 1'b0; nxt(); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_lane(i, 3'(i), 16'(16'h1000 + i));
      req_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
         if (c > 0) chk("rr_wr_en", 32'(wr_en), 32'(1 << ((c - 1) % 4)));
         nxt();
      end
      req_valid = '0;
      @(negedge clk); chk("rr_last_wr_en", 32'(wr_en), 32'h08);

      // hold right after a handshake.
      nxt(); set_lane(1, 3'd4, 16'hBEEF); req_valid = 4'b0010;
      @(negedge clk); chk("hold_pre_ready", 32'(req_ready), 32'h2);
      nxt(); hold = 1'b1; req_valid = 4'hF;
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_wr_en", 32'(wr_en), 32'h10);
      chk("hold_wr_data", 32'(wr_data), 32'hBEEF);
      nxt(); @(negedge clk); chk("hold2_ready", 32'(req_ready), 32'h0);
      nxt(); hold = 1'b0; @(negedge clk); chk("stall_exit_ready", 32'(req_ready), 32'h0);
      nxt(); @(negedge clk); chk("resume_ready", 32'(req_ready), 32'h4);
      nxt(); req_valid = '0;

      // Out-of-range address from requester 2.
      nxt(); e0 = int'(dut.error_drop);
      set_lane(2, 3'd7, 16'hDEAD); req_valid = 4'b0100;
      @(negedge clk); chk("drop_ready", 32'(req_ready), 32'h4);
      nxt(); req_valid = '0;
      @(negedge clk);
      chk("drop_wr_en", 32'(wr_en), 32'h0);
      chk("drop_busy", 32'(busy), 32'd1);
      chk("drop_count", 32'(dut.error_drop), 32'(e0 + 1));
      chk("drop_ptr", 32'(dut.ptr), 32'd3);

      // Reset right after a handshake discards the write.
      nxt(); set_lane(0, 3'd1, 16'h7777); req_valid = 4'b0001;
      @(negedge clk); chk("prerst_ready", 32'(req_ready), 32'h1);
      nxt(); rst_n = 1'b0; req_valid = '0;
      @(negedge clk);
      chk("midrst_wr_en", 32'(wr_en), 32'h0);
      chk("midrst_wr_data", 32'(wr_data), 32'h0);
      chk("midrst_ptr", 32'(dut.ptr), 32'd0);
      nxt(); rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_wr_en", 32'(wr_en), 32'h0);
      chk("postrst_busy", 32'(busy), 32'd0);

      // Two consecutive writes to register 2: last one wins.
      nxt(); set_lane(1, 3'd2, 16'h1111); req_valid = 4'b0010;
      nxt(); set_lane(3, 3'd2, 16'h2222); req_valid = 4'b1000;
      nxt(); req_valid = '0;
      nxt(); nxt();
      @(negedge clk);
      chk("same_addr_bank", 32'(bank[2]), 32'h2222);
      chk("same_addr_model", 32'(m_reg[2]), 32'h2222);

      // Mixed patterns with hold toggling and random addresses/data.
      foreach (mix[j]) begin
         nxt();
         for (int i = 0; i < 4; i++)
            set_lane(i, 3'($urandom_range(0, 7)), 16'($urandom));
         req_valid = mix[j].v; hold = mix[j].h;
      end
      nxt(); req_valid = '0; hold = 1'b0;
      nxt(); nxt();
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) chk("bank_final", 32'(bank[i]), 32'(m_reg[i]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
